// File: rtl/knn_vote.sv
// knn_vote: snapshots the sorted 7-entry nearest-candidate list, scans it one
// slot per cycle, tallies one vote per class label, and presents the winning
// class over a valid/ready handshake. Ties go to the class seen nearest.
module knn_vote #(
  parameter int          LABEL_W   = 2,
  parameter logic [17:0] EMPTY_VAL = 18'h3fff
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [17:0]        candidate0,
  input  logic [17:0]        candidate1,
  input  logic [17:0]        candidate2,
  input  logic [17:0]        candidate3,
  input  logic [17:0]        candidate4,
  input  logic [17:0]        candidate5,
  input  logic [17:0]        candidate6,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [LABEL_W-1:0] result_class,
  output logic [2:0]         result_votes,
  output logic [17:0]        result_nearest,
  output logic               no_data
);

  localparam int NCLS = 1 << LABEL_W;

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE, OUT} state_t;

  state_t                   r_state, w_next;
  logic [6:0][17:0]         r_snap;     // slot 0 is always the one being scanned
  logic [2:0]               r_idx;
  logic [NCLS-1:0][2:0]     r_votes;
  logic [NCLS-1:0][2:0]     r_first;
  logic                     r_any;
  logic [17:0]              r_nearest;

  logic [17:0]              w_cur;
  logic [LABEL_W-1:0]       w_lbl;
  logic                     w_empty;
  logic                     w_accept;
  logic [LABEL_W-1:0]       w_win_cls;
  logic [2:0]               w_win_votes;
  logic [2:0]               w_win_first;

  assign w_cur    = r_snap[0];
  assign w_lbl    = w_cur[LABEL_W-1:0];
  assign w_empty  = (w_cur == EMPTY_VAL);
  // A new request is taken from IDLE, or from OUT on the very edge the
  // pending result is handed off; everywhere else start is dropped.
  assign w_accept = start && ((r_state == IDLE) || ((r_state == OUT) && result_ready));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SCAN;
      SCAN:    if (r_idx == 3'd6) w_next = DECIDE;
      DECIDE:  w_next = OUT;
      OUT:     if (result_ready) w_next = start ? SCAN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Winner: highest vote count; on equal counts the smaller first index wins
  always_comb begin
    w_win_cls   = '0;
    w_win_votes = '0;
    w_win_first = 3'd7;
    for (int c = 0; c < NCLS; c++) begin
      if ((r_votes[c] != 3'd0) &&
          ((r_votes[c] > w_win_votes) ||
           ((r_votes[c] == w_win_votes) && (r_first[c] < w_win_first)))) begin
        w_win_cls   = LABEL_W'(c);
        w_win_votes = r_votes[c];
        w_win_first = r_first[c];
      end
    end
  end

  // Datapath: snapshot, serial tally, result registers and handshake flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_snap         <= '0;
      r_idx          <= '0;
      r_votes        <= '0;
      r_first        <= '0;
      r_any          <= 1'b0;
      r_nearest      <= '0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      result_class   <= '0;
      result_votes   <= '0;
      result_nearest <= '0;
      no_data        <= 1'b0;
    end else begin
      case (r_state)
        IDLE, OUT: begin
          if ((r_state == OUT) && result_ready) result_valid <= 1'b0;
          if (w_accept) begin
            r_snap    <= {candidate6, candidate5, candidate4, candidate3,
                          candidate2, candidate1, candidate0};
            r_idx     <= '0;
            r_votes   <= '0;
            r_first   <= '0;
            r_any     <= 1'b0;
            r_nearest <= '0;
            busy      <= 1'b1;
          end
        end
        SCAN: begin
          if (!w_empty) begin
            r_votes[w_lbl] <= r_votes[w_lbl] + 3'd1;
            if (r_votes[w_lbl] == 3'd0) r_first[w_lbl] <= r_idx;
            if (!r_any) begin
              r_any     <= 1'b1;
              r_nearest <= {{LABEL_W{1'b0}}, w_cur[17:LABEL_W]};
            end
          end
          r_snap <= {18'h0, r_snap[6:1]};
          r_idx  <= r_idx + 3'd1;
        end
        DECIDE: begin
          result_valid   <= 1'b1;
          busy           <= 1'b0;
          result_class   <= w_win_cls;
          result_votes   <= w_win_votes;
          result_nearest <= r_nearest;
          no_data        <= !r_any;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
// tb_knn_vote: randomized and directed stimulus for knn_vote. Expected
// results come from a list-level reference model and flow through a
// scoreboard queue; a monitor pops and compares on each handshake.
module tb_knn_vote;

  localparam logic [17:0] EMPTY = 18'h3fff;

  typedef logic [6:0][17:0] cv_t;
  typedef struct packed {
    logic [1:0]  cls;
    logic [2:0]  votes;
    logic [17:0] near;
    logic        nd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        result_ready = 1'b0;
  cv_t         cin = '0;
  logic        busy, result_valid, no_data;
  logic [1:0]  result_class;
  logic [2:0]  result_votes;
  logic [17:0] result_nearest;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  knn_vote #(.LABEL_W(2), .EMPTY_VAL(18'h3fff)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .candidate0(cin[0]), .candidate1(cin[1]), .candidate2(cin[2]),
    .candidate3(cin[3]), .candidate4(cin[4]), .candidate5(cin[5]),
    .candidate6(cin[6]),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .result_class(result_class), .result_votes(result_votes),
    .result_nearest(result_nearest), .no_data(no_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: count labels of non-empty slots, take the max count, then the
  // winner is the earliest non-empty slot whose label has that count.
  function automatic exp_t model(input cv_t c);
    int   cnt[4];
    int   maxv;
    bit   found;
    bit   picked;
    exp_t e;
    e = '0; maxv = 0; found = 0; picked = 0;
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    for (int i = 0; i < 7; i++) if (c[i] != EMPTY) cnt[c[i][1:0]]++;
    for (int k = 0; k < 4; k++) if (cnt[k] > maxv) maxv = cnt[k];
    e.nd = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (c[i] != EMPTY) begin
        if (!found) begin
          found = 1; e.nd = 1'b0; e.near = {2'b00, c[i][17:2]};
        end
        if (!picked && cnt[c[i][1:0]] == maxv) begin
          picked = 1; e.cls = c[i][1:0]; e.votes = 3'(maxv);
        end
      end
    end
    return e;
  endfunction

  function automatic cv_t mk(input int l[7]);
    cv_t c;
    for (int i = 0; i < 7; i++) c[i] = {16'(16 + i), 2'(l[i])};
    return c;
  endfunction

  function automatic cv_t rand_cands();
    cv_t c;
    int  k, d;
    k = $urandom_range(0, 7);
    d = $urandom_range(0, 255);
    for (int i = 0; i < 7; i++) begin
      if (i < k) begin
        d += $urandom_range(0, 1023);
        c[i] = {d[15:0], 2'($urandom_range(0, 3))};
      end else c[i] = EMPTY;
    end
    return c;
  endfunction

  // Monitor: every accepted result must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && result_valid && result_ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result: got class %0h with no expectation queued", result_class);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("class",   32'(result_class),   32'(e.cls));
        chk("votes",   32'(result_votes),   32'(e.votes));
        chk("nearest", 32'(result_nearest), 32'(e.near));
        chk("no_data", 32'(no_data),        32'(e.nd));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Count edges from the start edge until result_valid appears. With noisy
  // set, candidates are scrambled and start pulsed while the block is busy.
  task automatic wait_result(input bit noisy);
    int n;
    n = 0;
    while (!result_valid && n < 20) begin
      if (noisy) begin
        cin   = rand_cands();
        start = (n <= 7) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    chk("latency", 32'(n), 32'd8);
  endtask

  task automatic issue(input cv_t c, input bit noisy);
    cin = c; start = 1'b1;
    tick();
    sb.push_back(model(c));
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_result(noisy);
  endtask

  task automatic drain(input bit rnd_ready);
    int k;
    k = 0;
    while (result_valid && k < 40) begin
      result_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      k++;
    end
    result_ready = 1'b0;
    chk("valid_cleared", 32'(result_valid), 32'd0);
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] cls, input logic [2:0] v,
                          input logic [17:0] nr, input logic nd);
    chk({tag, "_class"},   32'(result_class),   32'(cls));
    chk({tag, "_votes"},   32'(result_votes),   32'(v));
    chk({tag, "_nearest"}, 32'(result_nearest), 32'(nr));
    chk({tag, "_no_data"}, 32'(no_data),        32'(nd));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lmaj[7] = '{1, 2, 1, 2, 3, 1, 0};
    int   ltie[7] = '{2, 1, 2, 1, 0, 3, 3};
    cv_t  maj, tie, part, empt;
    logic [1:0]  h_cls;
    logic [2:0]  h_votes;
    logic [17:0] h_near;

    maj  = mk(lmaj);
    tie  = mk(ltie);
    part = {EMPTY, EMPTY, EMPTY, EMPTY, 18'h000C0, 18'h00083, 18'h00043};
    empt = {7{EMPTY}};

    // Reset then idle
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("idle_busy",  32'(busy),         32'd0);
    chk("idle_valid", 32'(result_valid), 32'd0);
    chk_outs("idle", 2'd0, 3'd0, 18'd0, 1'b0);

    // Majority
    issue(maj, 0);
    drain(0);
    chk_outs("maj", 2'd1, 3'd3, 18'h10, 1'b0);

    // Tie resolved toward the nearest neighbour
    issue(tie, 0);
    drain(0);
    chk_outs("tie", 2'd2, 3'd2, 18'h10, 1'b0);

    // Partially filled list
    issue(part, 0);
    drain(0);
    chk_outs("part", 2'd3, 3'd2, 18'h10, 1'b0);

    // All empty
    issue(empt, 0);
    drain(0);
    chk_outs("empty", 2'd0, 3'd0, 18'd0, 1'b1);

    // Backpressure: outputs hold, start ignored; then handoff with restart
    issue(tie, 0);
    h_cls = result_class; h_votes = result_votes; h_near = result_nearest;
    for (int i = 0; i < 5; i++) begin
      cin = rand_cands(); start = 1'b1;
      tick();
      chk("stall_valid",   32'(result_valid),   32'd1);
      chk("stall_busy",    32'(busy),           32'd0);
      chk("stall_class",   32'(result_class),   32'(h_cls));
      chk("stall_votes",   32'(result_votes),   32'(h_votes));
      chk("stall_nearest", 32'(result_nearest), 32'(h_near));
    end
    cin = part; start = 1'b1; result_ready = 1'b1;
    tick();
    sb.push_back(model(part));
    start = 1'b0; result_ready = 1'b0;
    chk("overlap_busy",  32'(busy),         32'd1);
    chk("overlap_valid", 32'(result_valid), 32'd0);
    wait_result(0);
    drain(1);
    chk_outs("overlap", 2'd3, 3'd2, 18'h10, 1'b0);

    // Reset during SCAN at idx 3
    cin = tie; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_busy",  32'(busy),         32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk_outs("rst", 2'd0, 3'd0, 18'd0, 1'b0);
    tick();
    issue(maj, 0);
    drain(0);
    chk_outs("post_rst", 2'd1, 3'd3, 18'h10, 1'b0);

    // Randomized traffic with noisy inputs and random backpressure
    for (int r = 0; r < 40; r++) begin
      issue(rand_cands(), 1);
      drain(1);
    end

    tick(); tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/knn_vote.md
Name: knn_vote

Overview:
- Reader/consumer of the sorted 7-entry nearest-candidate list that the distance sorter produces.
- On a start strobe it snapshots candidate0..candidate6 and scans them serially, one per cycle.
- Each candidate's low bits are its class label; empty slots are skipped, and the block counts one vote per class.
- It then presents the winning class, vote count and nearest distance to the classification/display logic over a valid/ready handshake.

Parameters:
- LABEL_W, 2, width of the class label field in each candidate's low bits; there are 2^LABEL_W classes.
- EMPTY_VAL, 18'h3fff, candidate value marking an unfilled slot (equals the sorter's reset value).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- start  in  1  single-cycle request: snapshot the candidates and classify
- candidate0..candidate6  in  18 each  sorted list; candidate0 is the nearest; format {distance[17:LABEL_W], label[LABEL_W-1:0]}
- busy  out  1  high from the accepted start until result_valid rises
- result_valid  out  1  result available; held until accepted
- result_ready  in  1  downstream accepts when high together with result_valid
- result_class  out  LABEL_W  winning class
- result_votes  out  3  votes for the winning class, 0..7
- result_nearest  out  18  distance field of the first non-empty candidate, zero-extended; 0 if none
- no_data  out  1  all 7 snapshot slots were EMPTY_VAL

Behaviour:
- Reset (rst_n low at a clk edge): FSM to IDLE; busy, result_valid, result_class, result_votes, result_nearest, no_data all 0; vote counters, first-index trackers and snapshot registers cleared. Reset is honoured in every state, including mid-SCAN and while result_valid is pending; the pending result is discarded.
- FSM states: IDLE, SCAN, DECIDE, OUT.
- IDLE:
  - start high at edge T: latch the 7 candidates into snapshot registers, clear all counters, set idx=0, set busy=1, go to SCAN.
  - start low: stay in IDLE.
- SCAN (edges T+1..T+7, one slot per edge, idx 0..6):
  - Slot equal to EMPTY_VAL: ignored.
  - Otherwise: votes[label] += 1 (3-bit counter, cannot overflow).
  - If this is the first occurrence of the label, record first_idx[label] = idx.
  - If this is the first non-empty slot, record nearest = slot[17:LABEL_W].
  - After idx 6: go to DECIDE.
- DECIDE (edge T+8): register the outputs, set result_valid=1, busy=0, go to OUT.
  - Winner: the class with the maximum vote count.
  - Tie rule: among tied classes, pick the one with the smallest first_idx (the nearest neighbour wins).
  - All slots empty: result_class=0, result_votes=0, result_nearest=0, no_data=1.
- Latency: result_valid is first visible after edge T+8, i.e. 8 cycles after the start edge. Throughput is one classification per 9 cycles plus handshake stall.
- OUT:
  - Outputs held stable while result_valid=1 and result_ready=0.
  - On an edge with result_valid and result_ready both high: result_valid clears.
  - If start is also high on that same edge, the new snapshot is taken and the FSM goes directly to SCAN with busy=1. Otherwise the FSM goes to IDLE.
  - result_class, result_votes, result_nearest and no_data keep their last values until the next DECIDE.
- start while busy (SCAN/DECIDE), or in OUT without handshake acceptance: ignored, not queued.
- Candidate inputs are sampled only at the start edge; later changes do not affect the result in flight.

Test Plan:
- Reset then idle, no start for 20 cycles -> all outputs 0, busy=0.
- Majority: labels c0..c6 = 1,2,1,2,3,1,0 with distances 0x10..0x16, start, result_ready=1 -> result_valid rises exactly 8 cycles after start; result_class=1, result_votes=3, result_nearest=0x10, no_data=0; result_valid drops one cycle later.
- Tie: labels 2,1,2,1,0,3,3 -> classes 1, 2 and 3 each have 2 votes; result_class=2 (first_idx 0), result_votes=2.
- Partial/empty slots: c0=0x00043, c1=0x00083, c2=0x000C0, c3..c6=18'h3fff -> result_class=3, result_votes=2, result_nearest=0x10. Also all slots 18'h3fff -> no_data=1, result_class=0, result_votes=0, result_nearest=0; the empty slots' label bits (3) are not counted.
- Backpressure and overlap: result_ready low for 5 cycles -> outputs stable and start pulses ignored. Then result_ready=1 with start=1 on the same edge -> new snapshot taken, busy=1 next cycle, second result valid 8 cycles later.
- Reset mid-operation: assert rst_n=0 at SCAN idx 3 -> next edge in IDLE, busy=0, result_valid=0. A following start with the majority vector gives the same result as the majority scenario, with no residual counts.
